// File: rtl/cv32e40p_mult_tmr_ctrl.sv
// Sequencer for a triplicated multiplier: issues, waits on the voter, retries on faults.
// Define CV32E40P_TMR_FAULT_LOG_EN to enable the sticky replica/fault logging outputs.
module cv32e40p_mult_tmr_ctrl #(
   parameter int unsigned MAX_RETRY = 2,
   parameter int unsigned TIMEOUT   = 64,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   output logic             mult_en_o,
   output logic             mult_flush_o,
   input  logic             vote_ready_i,
   input  logic [31:0]      vote_result_i,
   input  logic             vote_faulty_i,
   input  logic [31:0]      rep_result_i1,
   input  logic [31:0]      rep_result_i2,
   input  logic [31:0]      rep_result_i3,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [31:0]      resp_result_o,
   output logic             resp_fault_o,
   input  logic             clr_i,
   output logic [2:0]       replica_err_o,
   output logic [CNT_W-1:0] fault_cnt_o,
   output logic             uncorrectable_o
);

   localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam int unsigned WAIT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
   localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RETRY,
      ST_RESP
   } state_t;

   state_t             state, state_next;
   logic [RETRY_W-1:0] retry_cnt, retry_next;
   logic [WAIT_W-1:0]  wait_cnt, wait_next;
   logic [31:0]        result, result_next;
   logic               fault, fault_next;
   logic               vote_event, tmo_event, exhausted;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         retry_cnt <= '0;
         wait_cnt  <= '0;
         result    <= '0;
         fault     <= 1'b0;
      end else begin
         state     <= state_next;
         retry_cnt <= retry_next;
         wait_cnt  <= wait_next;
         result    <= result_next;
         fault     <= fault_next;
      end
   end

   // All control outputs are gated by rst so a reset never leaks a flush or enable.
   always_comb begin
      state_next   = state;
      retry_next   = retry_cnt;
      wait_next    = wait_cnt;
      result_next  = result;
      fault_next   = fault;
      vote_event   = 1'b0;
      tmo_event    = 1'b0;
      exhausted    = 1'b0;
      req_ready_o  = 1'b0;
      mult_en_o    = 1'b0;
      mult_flush_o = 1'b0;
      resp_valid_o = 1'b0;
      if (!rst) begin
         unique case (state)
            ST_IDLE: begin
               req_ready_o = 1'b1;
               if (req_valid_i) begin
                  state_next = ST_ISSUE;
                  retry_next = '0;
               end
            end
            ST_ISSUE: begin
               mult_en_o  = 1'b1;
               wait_next  = '0;
               state_next = ST_WAIT;
            end
            ST_WAIT: begin
               mult_en_o = 1'b1;
               if (vote_ready_i) begin
                  if (!vote_faulty_i) begin
                     result_next = vote_result_i;
                     fault_next  = 1'b0;
                     state_next  = ST_RESP;
                  end else begin
                     vote_event = 1'b1;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  tmo_event = 1'b1;
               end else begin
                  wait_next = wait_cnt + 1'b1;
               end
               // A timeout is treated like a faulty vote, but delivers zero once retries run out.
               if (vote_event || tmo_event) begin
                  if (retry_cnt < RETRY_LIMIT) begin
                     retry_next = retry_cnt + 1'b1;
                     state_next = ST_RETRY;
                  end else begin
                     exhausted   = 1'b1;
                     result_next = vote_event ? vote_result_i : 32'h0;
                     fault_next  = 1'b1;
                     state_next  = ST_RESP;
                  end
               end
            end
            ST_RETRY: begin
               mult_flush_o = 1'b1;
               state_next   = ST_ISSUE;
            end
            ST_RESP: begin
               resp_valid_o = 1'b1;
               if (resp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign resp_result_o = resp_valid_o ? result : 32'h0;
   assign resp_fault_o  = resp_valid_o & fault;

`ifdef CV32E40P_TMR_FAULT_LOG_EN
   logic [2:0]       err, err_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             unc, unc_next;
   logic [2:0]       mismatch;

   assign mismatch = {rep_result_i3 != vote_result_i,
                      rep_result_i2 != vote_result_i,
                      rep_result_i1 != vote_result_i};

   // Clear is applied first so a coincident fault event still lands in the log.
   always_comb begin
      err_next = clr_i ? 3'b000 : err;
      cnt_next = clr_i ? '0 : cnt;
      unc_next = clr_i ? 1'b0 : unc;
      if (vote_event) err_next = err_next | mismatch;
      if ((vote_event || tmo_event) && (cnt_next != {CNT_W{1'b1}})) cnt_next = cnt_next + 1'b1;
      if (exhausted) unc_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 3'b000;
         cnt <= '0;
         unc <= 1'b0;
      end else begin
         err <= err_next;
         cnt <= cnt_next;
         unc <= unc_next;
      end
   end

   assign replica_err_o   = err;
   assign fault_cnt_o     = cnt;
   assign uncorrectable_o = unc;
`else
   logic unused_log;
   assign unused_log = ^{clr_i, rep_result_i1, rep_result_i2, rep_result_i3,
                         vote_event, tmo_event, exhausted};

   assign replica_err_o   = 3'b000;
   assign fault_cnt_o     = '0;
   assign uncorrectable_o = 1'b0;
`endif

endmodule

// File: doc/cv32e40p_mult_tmr_ctrl.md
CV32E40P_MULT_TMR_CTRL -- requirements
Module: cv32e40p_mult_tmr_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2: re-executions allowed after a voted fault before giving up.
REQ-002 SHALL have parameter TIMEOUT, default 64: max WAIT cycles without vote_ready_i.
REQ-003 SHALL have parameter CNT_W, default 16: fault counter width.
REQ-004 SHALL have ports; reset is synchronous and active-high:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid_i  in  1  multiply request pending
- req_ready_o  out  1  request accepted this cycle
- mult_en_o  out  1  broadcast enable to all three multiplier replicas
- mult_flush_o  out  1  one-cycle replica flush before re-execution
- vote_ready_i  in  1  voted ready from the multiplier voter
- vote_result_i  in  32  voted result
- vote_faulty_i  in  1  voter disagreement flag
- rep_result_i1/i2/i3  in  32 each  raw replica results
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  consumer accepts response
- resp_result_o  out  32  delivered result
- resp_fault_o  out  1  response delivered after retries exhausted
- clr_i  in  1  clear sticky status and counter
- replica_err_o  out  3  sticky per-replica mismatch flags
- fault_cnt_o  out  CNT_W  saturating fault count
- uncorrectable_o  out  1  sticky: retries exhausted at least once

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, WAIT, RETRY, RESP.
REQ-006 IDLE: req_ready_o=1; req_valid_i=1 -> ISSUE, retry count cleared; all other outputs low.
REQ-007 ISSUE: mult_en_o=1 for one cycle -> WAIT; WAIT holds mult_en_o=1 and counts cycles from 0.
REQ-008 WAIT, vote_ready_i=1 and vote_faulty_i=0 -> register vote_result_i into resp_result_o, resp_fault_o=0, -> RESP.
REQ-009 WAIT, vote_ready_i=1 and vote_faulty_i=1 -> fault event; if retry count < MAX_RETRY -> RETRY and increment retry count, else register vote_result_i, resp_fault_o=1, set uncorrectable_o, -> RESP.
REQ-010 WAIT cycle count reaching TIMEOUT with no vote_ready_i -> fault event handled as REQ-009, no replica flag set; on exhaustion resp_result_o=0.
REQ-011 Per fault event from a vote, replica_err_o[k] SHALL set where rep_result_ik != vote_result_i (k=1..3 -> bit 0..2).
REQ-012 RETRY: mult_flush_o=1 and mult_en_o=0 for exactly one cycle -> ISSUE.
REQ-013 RESP: resp_valid_o=1, resp_result_o/resp_fault_o stable until resp_ready_i=1 -> IDLE; back-to-back request accepted no earlier than the following IDLE cycle.
REQ-014 Fault-free latency: request accepted cycle N, ISSUE N+1, resp_valid_o at earliest N+3 when vote_ready_i at N+2.
REQ-015 fault_cnt_o SHALL increment by 1 per fault event, saturating at all-ones.
REQ-016 clr_i clears replica_err_o, fault_cnt_o, uncorrectable_o; simultaneous with a fault event, the event wins (count=1, flags of that event set).
REQ-017 clr_i SHALL NOT affect FSM state or an in-flight request.

Reset
REQ-018 rst=1 SHALL force IDLE, retry/timeout counts 0, and every output 0 except req_ready_o, which is 1 in the cycle after reset release.
REQ-019 rst mid-operation SHALL abandon the request with no response and no mult_flush_o pulse.

Configuration
REQ-020 With CV32E40P_TMR_FAULT_LOG_EN defined: replica_err_o, fault_cnt_o, uncorrectable_o and clr_i behave per REQ-011, REQ-015, REQ-016.
REQ-021 Without it: those outputs tied 0, clr_i ignored; retry, timeout and resp_fault_o behaviour unchanged.

Verification
REQ-022 Request, vote_ready_i after 1 cycle, faulty=0, result 0x0000_1234 -> resp_result_o=0x0000_1234, resp_fault_o=0, fault_cnt_o=0.
REQ-023 First vote faulty, rep_result_i2=0xDEAD_BEEF, others 0x10 -> one mult_flush_o pulse, re-issue, second vote clean 0x10 delivered; replica_err_o=3'b010, fault_cnt_o=1.
REQ-024 Three consecutive faulty votes (MAX_RETRY=2) -> two flushes, resp_fault_o=1, uncorrectable_o=1, fault_cnt_o=3, voted value delivered.
REQ-025 vote_ready_i never asserted -> after 64 WAIT cycles RETRY; after 3 timeouts resp_result_o=0, resp_fault_o=1.
REQ-026 resp_ready_i held low 5 cycles -> resp_valid_o and data stable 5 cycles, req_ready_o=0 throughout.
REQ-027 rst asserted in WAIT -> next cycle IDLE, all outputs 0; clr_i coincident with a fault -> fault_cnt_o=1.
